// File: rtl/imem_loader.sv
// imem_loader: boot loader that assembles big-endian words from a byte stream into instruction memory
// and holds the core in reset until a frame passes its XOR checksum.
module imem_loader #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        pc_reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN_HI  = 4'd1;
    localparam logic [3:0] S_LEN_LO  = 4'd2;
    localparam logic [3:0] S_DATA_HI = 4'd3;
    localparam logic [3:0] S_DATA_LO = 4'd4;
    localparam logic [3:0] S_WRITE   = 4'd5;
    localparam logic [3:0] S_CHECK   = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERR     = 4'd8;
    localparam logic [16:0] MAX_LEN  = 17'd1 << ADDR_WIDTH;

    logic [3:0]            r_state;
    logic [15:0]           r_len;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [7:0]            r_acc;
    logic [15:0]           r_wdata;
    logic                  r_we;
    logic                  r_hold;
    logic                  r_done;
    logic                  r_err;
    logic                  w_fire;
    logic                  w_sync;
    logic [15:0]           w_len;
    logic [ADDR_WIDTH:0]   w_cnt_nxt;

    assign rx_ready   = r_state != S_WRITE;
    assign w_fire     = rx_valid && rx_ready;
    assign w_sync     = w_fire && rx_data == SYNC_BYTE;
    assign w_len      = {r_len[15:8], rx_data};
    assign w_cnt_nxt  = r_cnt + 1'b1;
    assign imem_we    = r_we;
    assign imem_addr  = 16'(r_cnt);
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign error      = r_err;
    assign word_count = 16'(r_cnt);

    // the write counter doubles as the word count; it is one bit wider so a full-depth load fits
    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: if (w_sync) begin
                    r_state <= S_LEN_HI;
                    r_hold  <= 1'b1;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                    r_acc   <= '0;
                end
                S_LEN_HI: if (w_fire) begin
                    r_len[15:8] <= rx_data;
                    r_state     <= S_LEN_LO;
                end
                S_LEN_LO: if (w_fire) begin
                    r_len[7:0] <= rx_data;
                    r_err      <= {1'b0, w_len} > MAX_LEN;
                    r_state    <= w_len == 16'd0 ? S_CHECK :
                                  {1'b0, w_len} > MAX_LEN ? S_ERR : S_DATA_HI;
                end
                S_DATA_HI: if (w_fire) begin
                    r_wdata[15:8] <= rx_data;
                    r_acc         <= r_acc ^ rx_data;
                    r_state       <= S_DATA_LO;
                end
                S_DATA_LO: if (w_fire) begin
                    r_wdata[7:0] <= rx_data;
                    r_acc        <= r_acc ^ rx_data;
                    r_we         <= 1'b1;
                    r_state      <= S_WRITE;
                end
                S_WRITE: begin
                    r_cnt   <= w_cnt_nxt;
                    r_state <= 16'(w_cnt_nxt) == r_len ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: if (w_fire) begin
                    r_done  <= rx_data == r_acc;
                    r_err   <= rx_data != r_acc;
                    r_hold  <= rx_data != r_acc;
                    r_state <= rx_data == r_acc ? S_DONE : S_ERR;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames against a frame-level model; expected writes are queued
// by the stimulus and popped by an independent write monitor.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        pc_reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, imem_we, cpu_hold, done, error;
    logic [15:0] imem_addr, imem_wdata, word_count;

    imem_loader #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .pc_reset(pc_reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int          errs = 0;
    int          checks = 0;
    bit          gaps = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!pc_reset) begin
            check("ready_not_we", 32'(rx_ready), 32'(!imem_we));
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_addr, imem_wdata);
                end else
                    check("write_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        if (gaps && $urandom_range(0, 1) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10) begin
            checks++;
            errs++;
            $display("FAIL ready_timeout: rx_ready stayed 0, expected 1 within 10 cycles");
        end
        @(posedge clk);
    endtask

    task automatic check_reset();
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_ready", 32'(rx_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", 32'(imem_wdata), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
    endtask

    task automatic frame(input int len, input bit bad, input bit noise, input bit fixed);
        logic [15:0] l16 = 16'(len);
        logic [15:0] w;
        logic [7:0]  x = 8'h00;
        time         t0, t1;
        if (noise) begin
            send_byte(8'h00);
            send_byte(8'hFF);
        end
        send_byte(8'hA5);
        t0 = $time;
        #1;
        check("sync_hold", 32'(cpu_hold), 32'd1);
        check("sync_done", 32'(done), 32'd0);
        check("sync_error", 32'(error), 32'd0);
        check("sync_wc", 32'(word_count), 32'd0);
        send_byte(l16[15:8]);
        send_byte(l16[7:0]);
        if (len > 256) begin
            #1;
            check("len_err", 32'(error), 32'd1);
            check("len_done", 32'(done), 32'd0);
            check("len_hold", 32'(cpu_hold), 32'd1);
        end else begin
            for (int i = 0; i < len; i++) begin
                w = fixed ? (i == 0 ? 16'h1234 : 16'hABCD) : 16'($urandom);
                exp_q.push_back({16'(i), w});
                x ^= w[15:8] ^ w[7:0];
                send_byte(w[15:8]);
                send_byte(w[7:0]);
            end
            send_byte(bad ? x ^ 8'h01 : x);
            t1 = $time;
            #1;
            check("end_done", 32'(done), 32'(!bad));
            check("end_error", 32'(error), 32'(bad));
            check("end_hold", 32'(cpu_hold), 32'(bad));
            check("end_wc", 32'(word_count), 32'(len));
            check("writes_drained", 32'(exp_q.size()), 32'd0);
            if (!gaps) check("frame_cycles", 32'((t1 - t0) / 10), 32'(3 + 3 * len));
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset();
        pc_reset = 1'b0;
        frame(2, 1'b0, 1'b1, 1'b1);
        frame(2, 1'b1, 1'b0, 1'b1);
        frame(2, 1'b0, 1'b0, 1'b1);
        frame(0, 1'b0, 1'b0, 1'b0);
        frame(257, 1'b0, 1'b0, 1'b0);
        gaps = 1'b1;
        frame(3, 1'b0, 1'b1, 1'b0);
        frame(3, 1'b1, 1'b0, 1'b0);
        frame(5, 1'b0, 1'b0, 1'b0);
        gaps = 1'b0;
        #2 pc_reset = 1'b1;
        #1 check_reset();
        @(negedge clk);
        pc_reset = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h11);
        #2 pc_reset = 1'b1;
        #1 check_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        pc_reset = 1'b0;
        frame(3, 1'b0, 1'b0, 1'b0);
        frame(256, 1'b0, 1'b0, 1'b0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
